// File: rtl/ctu_clsp_pllreq_if.sv
// ctu_clsp_pllreq_if: request/status bundle between the reset
// sequencer side (master) and the PLL relock requester (slave).
interface ctu_clsp_pllreq_if;
  logic wrm_rst_req;
  logic fc_req;
  logic tst_rst_req;
  logic pll_locked_jl;
  logic clr_err;
  logic wrm_rst_ref;
  logic wrm_rst_fc_ref;
  logic tst_rst_ref;
  logic req_busy;
  logic relock_done;
  logic req_drop;
  logic relock_err;

  modport master (
    output wrm_rst_req,
    output fc_req,
    output tst_rst_req,
    output pll_locked_jl,
    output clr_err,
    input  wrm_rst_ref,
    input  wrm_rst_fc_ref,
    input  tst_rst_ref,
    input  req_busy,
    input  relock_done,
    input  req_drop,
    input  relock_err
  );

  modport slave (
    input  wrm_rst_req,
    input  fc_req,
    input  tst_rst_req,
    input  pll_locked_jl,
    input  clr_err,
    output wrm_rst_ref,
    output wrm_rst_fc_ref,
    output tst_rst_ref,
    output req_busy,
    output relock_done,
    output req_drop,
    output relock_err
  );
endinterface

// File: rtl/ctu_clsp_pllreq.sv
// ctu_clsp_pllreq: jbus_clk-side PLL relock requester.
// Optional CTU_PLLREQ_QUEUE_EN adds a one-entry pending request queue.
module ctu_clsp_pllreq #(
  parameter int unsigned REQ_HOLD_CNT = 8,
  parameter logic [15:0] DROP_TO      = 16'h0100,
  parameter logic [15:0] LCK_TO       = 16'hFFFF
) (
  input logic               jbus_clk,
  input logic               rst_l,
  ctu_clsp_pllreq_if.slave  bus
);

  localparam int I_IDLE  = 0;
  localparam int I_ASRT  = 1;
  localparam int I_REL   = 2;
  localparam int I_WDROP = 3;
  localparam int I_WLCK  = 4;
  localparam int I_DONE  = 5;
  localparam int I_ERR   = 6;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_ASRT  = 7'b0000010,
    S_REL   = 7'b0000100,
    S_WDROP = 7'b0001000,
    S_WLCK  = 7'b0010000,
    S_DONE  = 7'b0100000,
    S_ERR   = 7'b1000000
  } state_t;

  localparam logic [15:0] HOLD_M1 = 16'(REQ_HOLD_CNT - 1);
  localparam logic [15:0] DROP_M1 = DROP_TO - 16'd1;
  localparam logic [15:0] LCK_M1  = LCK_TO - 16'd1;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_gap;
  logic [2:0]  r_ref;
  logic        r_seen;
  logic        r_drop;
  logic        r_err;
`ifdef CTU_PLLREQ_QUEUE_EN
  logic        r_q_vld;
  logic [2:0]  r_q_type;
`endif

  logic [2:0]  w_req;
  logic [2:0]  w_sel;
  logic        w_any;
  logic        w_multi;
  logic        w_gap_ok;
  logic        w_lock;

  // request vector is {fc, wrm, tst}; fc has highest priority
  assign w_req    = {bus.fc_req, bus.wrm_rst_req, bus.tst_rst_req};
  assign w_any    = |w_req;
  assign w_sel    = w_req[2] ? 3'b100 :
                    w_req[1] ? 3'b010 :
                    {2'b00, w_req[0]};
  assign w_multi  = w_any & (w_req != w_sel);
  assign w_gap_ok = (r_gap == 16'd0);
  assign w_lock   = bus.pll_locked_jl;

  // relock sequencer; r_gap enforces the low time between ref pulses
  always_ff @(posedge jbus_clk) begin
    if (!rst_l) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_ref    <= '0;
      r_seen   <= 1'b0;
      r_drop   <= 1'b0;
      r_err    <= 1'b0;
`ifdef CTU_PLLREQ_QUEUE_EN
      r_q_vld  <= 1'b0;
      r_q_type <= '0;
`endif
    end else begin
      r_drop <= 1'b0;
      if (!w_gap_ok) r_gap <= r_gap - 16'd1;
      if (bus.clr_err) r_err <= 1'b0;

      unique case (1'b1)
        r_state[I_IDLE]: begin
          r_cnt  <= '0;
          r_seen <= 1'b0;
`ifdef CTU_PLLREQ_QUEUE_EN
          if (r_q_vld) begin
            r_drop <= w_any;
            if (w_gap_ok && w_lock) begin
              r_ref   <= r_q_type;
              r_q_vld <= 1'b0;
              r_state <= S_ASRT;
            end
          end else if (w_any) begin
            if (!w_lock) begin
              r_drop <= 1'b1;
            end else if (w_gap_ok) begin
              r_ref   <= w_sel;
              r_drop  <= w_multi;
              r_state <= S_ASRT;
            end else begin
              r_q_vld  <= 1'b1;
              r_q_type <= w_sel;
              r_drop   <= w_multi;
            end
          end
`else
          if (w_any) begin
            if (w_lock && w_gap_ok) begin
              r_ref   <= w_sel;
              r_drop  <= w_multi;
              r_state <= S_ASRT;
            end else begin
              r_drop <= 1'b1;
            end
          end
`endif
        end
        r_state[I_ASRT]: begin
          if (!w_lock) r_seen <= 1'b1;
          if (r_cnt == HOLD_M1) begin
            r_ref   <= '0;
            r_cnt   <= '0;
            r_gap   <= HOLD_M1;
            r_state <= S_REL;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        r_state[I_REL]: begin
          r_cnt   <= '0;
          r_state <= (r_seen || !w_lock) ? S_WLCK : S_WDROP;
        end
        r_state[I_WDROP]: begin
          if (!w_lock) begin
            r_cnt   <= '0;
            r_state <= S_WLCK;
          end else if (r_cnt == DROP_M1) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        r_state[I_WLCK]: begin
          if (w_lock) begin
            r_state <= S_DONE;
          end else if (r_cnt == LCK_M1) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        r_state[I_DONE]: begin
          r_gap   <= HOLD_M1;
          r_state <= S_IDLE;
        end
        r_state[I_ERR]: begin
          r_err   <= 1'b1;
          r_gap   <= HOLD_M1;
          r_state <= S_IDLE;
`ifdef CTU_PLLREQ_QUEUE_EN
          r_drop  <= w_any | r_q_vld;
          r_q_vld <= 1'b0;
`else
          r_drop  <= w_any;
`endif
        end
        default: begin
          r_ref   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      if (!r_state[I_IDLE] && !r_state[I_ERR] && w_any) begin
`ifdef CTU_PLLREQ_QUEUE_EN
        if (!r_q_vld) begin
          r_q_vld  <= 1'b1;
          r_q_type <= w_sel;
          r_drop   <= w_multi;
        end else begin
          r_drop <= 1'b1;
        end
`else
        r_drop <= 1'b1;
`endif
      end
    end
  end

  assign bus.wrm_rst_fc_ref = r_ref[2];
  assign bus.wrm_rst_ref    = r_ref[1];
  assign bus.tst_rst_ref    = r_ref[0];
  assign bus.req_busy       = ~r_state[I_IDLE];
  assign bus.relock_done    = r_state[I_DONE];
  assign bus.req_drop       = r_drop;
  assign bus.relock_err     = r_err;

endmodule

// File: tb/tb_ctu_clsp_pllreq.sv
// tb_ctu_clsp_pllreq: directed bench for the PLL relock requester.
// Instance b uses a short lock timeout for the lock-never-returns case.
module tb_ctu_clsp_pllreq;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctu_clsp_pllreq_if a ();
  ctu_clsp_pllreq_if b ();

  ctu_clsp_pllreq u_a (
    .jbus_clk (clk),
    .rst_l    (rst_l),
    .bus      (a)
  );

  ctu_clsp_pllreq #(.LCK_TO(16'h0040)) u_b (
    .jbus_clk (clk),
    .rst_l    (rst_l),
    .bus      (b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] oa, ob;
    rst_l = 1'b0;
    a.wrm_rst_req = 0; a.fc_req = 0; a.tst_rst_req = 0;
    a.clr_err = 0; a.pll_locked_jl = 1;
    b.wrm_rst_req = 0; b.fc_req = 0; b.tst_rst_req = 0;
    b.clr_err = 0; b.pll_locked_jl = 1;
    repeat (4) tick();
    oa = {a.wrm_rst_ref, a.wrm_rst_fc_ref, a.tst_rst_ref, a.req_busy,
          a.relock_done, a.req_drop, a.relock_err};
    ob = {b.wrm_rst_ref, b.wrm_rst_fc_ref, b.tst_rst_ref, b.req_busy,
          b.relock_done, b.req_drop, b.relock_err};
    n_chk++;
    if (oa !== 7'b0) begin
      n_fail++; $display("FAIL reset_a: got %b want 0000000", oa);
    end
    n_chk++;
    if (ob !== 7'b0) begin
      n_fail++; $display("FAIL reset_b: got %b want 0000000", ob);
    end
    rst_l = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_wrm_relock;
    int first = -1;
    int cnt = 0;
    int oth = 0;
    int dn = 0;
    int errs = 0;
    a.wrm_rst_req = 1; tick(); a.wrm_rst_req = 0;
    n_chk++;
    if (a.req_busy !== 1'b1) begin
      n_fail++; $display("FAIL wrm_busy: got %b want 1", a.req_busy);
    end
    for (int t = 1; t <= 340; t++) begin
      if (a.wrm_rst_ref === 1'b1) begin
        cnt++;
        if (first < 0) first = t;
      end
      if (a.wrm_rst_fc_ref !== 1'b0 || a.tst_rst_ref !== 1'b0) oth++;
      if (a.relock_done === 1'b1) dn++;
      if (a.relock_err === 1'b1) errs++;
      a.pll_locked_jl = !(t >= 19 && t < 319);
      tick();
    end
    n_chk++;
    if (first !== 1) begin
      n_fail++; $display("FAIL wrm_first: got %0d want 1", first);
    end
    n_chk++;
    if (cnt !== 8) begin
      n_fail++; $display("FAIL wrm_hold: got %0d want 8", cnt);
    end
    n_chk++;
    if (oth !== 0) begin
      n_fail++; $display("FAIL wrm_others: got %0d want 0", oth);
    end
    n_chk++;
    if (dn !== 1) begin
      n_fail++; $display("FAIL wrm_done: got %0d want 1", dn);
    end
    n_chk++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL wrm_err: got %0d want 0", errs);
    end
    n_chk++;
    if (a.req_busy !== 1'b0) begin
      n_fail++; $display("FAIL wrm_idle: got %b want 0", a.req_busy);
    end
  endtask

  task automatic test_fc_tst_prio;
    int tst_seen = 0;
    int dn = 0;
    repeat (12) tick();
    a.fc_req = 1; a.tst_rst_req = 1; tick();
    a.fc_req = 0; a.tst_rst_req = 0;
    n_chk++;
    if (a.wrm_rst_fc_ref !== 1'b1) begin
      n_fail++; $display("FAIL prio_fc: got %b want 1", a.wrm_rst_fc_ref);
    end
    n_chk++;
    if (a.req_drop !== 1'b1) begin
      n_fail++; $display("FAIL prio_drop: got %b want 1", a.req_drop);
    end
    n_chk++;
    if (a.wrm_rst_ref !== 1'b0) begin
      n_fail++; $display("FAIL prio_wrm: got %b want 0", a.wrm_rst_ref);
    end
    for (int t = 1; t <= 40; t++) begin
      if (a.tst_rst_ref !== 1'b0) tst_seen++;
      if (a.relock_done === 1'b1) dn++;
      a.pll_locked_jl = !(t >= 11 && t < 16);
      tick();
    end
    n_chk++;
    if (tst_seen !== 0) begin
      n_fail++; $display("FAIL prio_tst: got %0d want 0", tst_seen);
    end
    n_chk++;
    if (dn !== 1) begin
      n_fail++; $display("FAIL prio_done: got %0d want 1", dn);
    end
  endtask

  task automatic test_drop_timeout;
    int t_err = -1;
    int dn = 0;
    logic busy_e = 1'bx;
    repeat (12) tick();
    a.wrm_rst_req = 1; tick(); a.wrm_rst_req = 0;
    for (int t = 1; t <= 400; t++) begin
      if (a.relock_done === 1'b1) dn++;
      if (a.relock_err === 1'b1) begin
        t_err = t;
        busy_e = a.req_busy;
        break;
      end
      tick();
    end
    n_chk++;
    if (t_err < 265 || t_err > 268) begin
      n_fail++; $display("FAIL dto_time: got %0d want 265..268", t_err);
    end
    n_chk++;
    if (dn !== 0) begin
      n_fail++; $display("FAIL dto_done: got %0d want 0", dn);
    end
    n_chk++;
    if (busy_e !== 1'b0) begin
      n_fail++; $display("FAIL dto_busy: got %b want 0", busy_e);
    end
    a.clr_err = 1; tick(); a.clr_err = 0;
    n_chk++;
    if (a.relock_err !== 1'b0) begin
      n_fail++; $display("FAIL dto_clr: got %b want 0", a.relock_err);
    end
  endtask

  task automatic test_lck_timeout;
    int t_err = -1;
    int dn = 0;
    logic [2:0] refs = 3'bxxx;
    repeat (4) tick();
    b.wrm_rst_req = 1; tick(); b.wrm_rst_req = 0;
    for (int t = 1; t <= 200; t++) begin
      if (b.relock_done === 1'b1) dn++;
      if (b.relock_err === 1'b1) begin
        t_err = t;
        refs = {b.wrm_rst_ref, b.wrm_rst_fc_ref, b.tst_rst_ref};
        break;
      end
      b.pll_locked_jl = !(t >= 11);
      tick();
    end
    n_chk++;
    if (t_err - 12 < 64 || t_err - 12 > 66) begin
      n_fail++; $display("FAIL lto_time: got %0d want 64..66", t_err - 12);
    end
    n_chk++;
    if (refs !== 3'b000) begin
      n_fail++; $display("FAIL lto_refs: got %b want 000", refs);
    end
    n_chk++;
    if (dn !== 0) begin
      n_fail++; $display("FAIL lto_done: got %0d want 0", dn);
    end
    b.pll_locked_jl = 1;
    b.clr_err = 1; tick(); b.clr_err = 0;
  endtask

  task automatic test_busy_req;
    int t_done = -1;
    int t_tst = -1;
    logic drop20 = 1'bx;
    int idle_ok = 0;
    repeat (12) tick();
    a.wrm_rst_req = 1; tick(); a.wrm_rst_req = 0;
    for (int t = 1; t <= 120; t++) begin
      if (t == 20) begin
        drop20 = a.req_drop;
        a.tst_rst_req = 0;
      end
      if (a.relock_done === 1'b1 && t_done < 0) t_done = t;
      if (a.tst_rst_ref === 1'b1 && t_tst < 0) t_tst = t;
      if (t == 19) a.tst_rst_req = 1;
      a.pll_locked_jl = !(t >= 11 && t < 39);
      tick();
    end
`ifdef CTU_PLLREQ_QUEUE_EN
    n_chk++;
    if (drop20 !== 1'b0) begin
      n_fail++; $display("FAIL busy_q_drop: got %b want 0", drop20);
    end
    n_chk++;
    if (t_done < 0 || t_tst < 0 || t_tst - t_done < 8) begin
      n_fail++;
      $display("FAIL busy_q_gap: done %0d tst %0d want gap >= 8",
               t_done, t_tst);
    end
`else
    n_chk++;
    if (drop20 !== 1'b1) begin
      n_fail++; $display("FAIL busy_drop: got %b want 1", drop20);
    end
    n_chk++;
    if (t_tst !== -1 || t_done < 0) begin
      n_fail++;
      $display("FAIL busy_tst: tst %0d done %0d want -1 and >0",
               t_tst, t_done);
    end
`endif
    for (int i = 0; i < 400; i++) begin
      if (a.req_busy === 1'b0) begin
        idle_ok = 1;
        break;
      end
      tick();
    end
    n_chk++;
    if (idle_ok !== 1) begin
      n_fail++; $display("FAIL busy_idle: got %0d want 1", idle_ok);
    end
    a.clr_err = 1; tick(); a.clr_err = 0;
  endtask

  task automatic test_reset_mid;
    logic [6:0] oa;
    repeat (12) tick();
    a.wrm_rst_req = 1; tick(); a.wrm_rst_req = 0;
    repeat (3) tick();
    n_chk++;
    if (a.wrm_rst_ref !== 1'b1) begin
      n_fail++; $display("FAIL mid_ref: got %b want 1", a.wrm_rst_ref);
    end
    rst_l = 1'b0; tick();
    oa = {a.wrm_rst_ref, a.wrm_rst_fc_ref, a.tst_rst_ref, a.req_busy,
          a.relock_done, a.req_drop, a.relock_err};
    n_chk++;
    if (oa !== 7'b0) begin
      n_fail++; $display("FAIL mid_rst: got %b want 0000000", oa);
    end
    rst_l = 1'b1;
    a.pll_locked_jl = 0;
    a.fc_req = 1; tick(); a.fc_req = 0;
    n_chk++;
    if (a.req_drop !== 1'b1) begin
      n_fail++; $display("FAIL nolock_drop: got %b want 1", a.req_drop);
    end
    n_chk++;
    if ({a.req_busy, a.wrm_rst_fc_ref} !== 2'b00) begin
      n_fail++;
      $display("FAIL nolock_idle: got %b want 00",
               {a.req_busy, a.wrm_rst_fc_ref});
    end
    tick();
    n_chk++;
    if (a.req_drop !== 1'b0) begin
      n_fail++; $display("FAIL nolock_pulse: got %b want 0", a.req_drop);
    end
    a.pll_locked_jl = 1;
  endtask

  initial begin
    test_reset();
    test_wrm_relock();
    test_fc_tst_prio();
    test_drop_timeout();
    test_lck_timeout();
    test_busy_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
